pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the 5-stage segmented processor. It decides every cycle whether each pipeline register advances, holds or takes a bubble. It covers load-use stalls, taken-branch and jump flushes, and data-memory wait freezes, with a timeout watchdog. It reads the 10-bit control words carried in ID, ID/EX and EX/MEM, and drives the write-enables and bubble/flush strobes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum consecutive freeze cycles allowed for one data-memory access.
- COUNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_ctrl  in  10  control word of the instruction in ID.
- id_rs, id_rt  in  5 each  source register fields in ID.
- ex_ctrl  in  10  control word in ID/EX.
- ex_rt  in  5  rt field in ID/EX (destination of a load).
- mem_ctrl  in  10  control word in EX/MEM.
- mem_zero  in  1  latched ALU zero flag in EX/MEM.
- dmem_ready  in  1  data memory has completed the current access.
- pc_we, ifid_we, idex_we, exmem_we  out  1 each  register write-enables.
- pc_sel  out  2  next-PC source: 00 = sequential, 01 = branch target, 10 = jump target.
- ifid_flush, idex_bubble, exmem_bubble, memwb_bubble  out  1 each  load all-zero control or instruction into that register.
- mem_err  out  1  sticky flag: memory-wait timeout occurred.
- stall_cnt, flush_cnt  out  COUNT_W each  saturating event counters.

Control-word bits: [9] jump, [8] RegDest, [7] ALUSrc, [6] MemToReg, [5] RegWrite, [4] MemRead, [3] MemWrite, [2] Branch, [1:0] ALUOp.

## Operation
Event terms:
- mem_access = mem_ctrl[4] | mem_ctrl[3].
- freeze = mem_access & ~dmem_ready & (wait_cnt != MEM_TIMEOUT).
- br_taken = mem_ctrl[2] & mem_zero.
- jump = id_ctrl[9].
- uses_rt = id_ctrl[8] | id_ctrl[3] | id_ctrl[2].
- load_use = ex_ctrl[4] & (ex_rt != 0) & ~id_ctrl[9] & ((ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).

Priority, highest first; only the first matching row applies:
- freeze: all *_we = 0, memwb_bubble = 1, other strobes 0, pc_sel = 00.
- br_taken: pc_we = 1, pc_sel = 01, ifid_flush = idex_bubble = exmem_bubble = 1, all other *_we = 1.
- jump: pc_we = 1, pc_sel = 10, ifid_flush = 1, all other *_we = 1.
- load_use: pc_we = ifid_we = 0, idex_bubble = 1, idex_we = exmem_we = 1.
- otherwise: all *_we = 1, all strobes 0, pc_sel = 00.

FSM:
- States are RUN and MEM_WAIT; wait_cnt is ceil(log2(MEM_TIMEOUT+1)) bits.
- RUN: when freeze, go to MEM_WAIT with wait_cnt = 1.
- MEM_WAIT, dmem_ready = 1: go to RUN with wait_cnt = 0.
- MEM_WAIT, wait_cnt == MEM_TIMEOUT with dmem_ready = 0: freeze drops (the access is abandoned and the pipeline advances), mem_err <= 1, go to RUN with wait_cnt = 0.
- MEM_WAIT, otherwise: wait_cnt increments.

Counters:
- stall_cnt +1 per cycle with freeze or load_use.
- flush_cnt +1 per cycle with br_taken or jump while not frozen.
- Both saturate at all-ones.
- mem_err clears only on reset.

## Timing
- Outputs are combinational from the current inputs, state and wait_cnt. There are no pipeline registers on the outputs.
- Decisions therefore take effect at the same clock edge.
- A load-use stall is exactly 1 cycle, since the load leaves EX on that edge.
- A branch or jump flush is 1 cycle.
- A memory access is frozen for min(latency, MEM_TIMEOUT) cycles.
- While reset is low:
  - pc_we = ifid_we = idex_we = exmem_we = 0.
  - ifid_flush = idex_bubble = exmem_bubble = memwb_bubble = 1.
  - pc_sel = 00; state = RUN; wait_cnt = 0; counters = 0; mem_err = 0.
- Reset asserted mid-freeze aborts the wait immediately.
- br_taken together with mem_access cannot legally occur, but freeze still wins.
- A load_use or jump that is masked by freeze or br_taken is re-evaluated on the next cycle.

## Structure
- Shared package pipeline_pkg holds:
  - control-bit index constants (CTL_JUMP=9 … CTL_ALUOP=1:0);
  - pc_sel encodings PCSEL_SEQ/BR/JMP;
  - the FSM state enum.
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, count), instantiated twice for stall_cnt and flush_cnt.

## Test plan
- Load r2 in EX, add r3,r2,r4 in ID → 1 cycle with pc_we=0, ifid_we=0, idex_bubble=1; next cycle normal; stall_cnt=1.
- Same load with ex_rt=0, or a jump in ID whose rs field is 2 → no stall.
- beq in MEM with mem_zero=1 → pc_sel=01, ifid_flush/idex_bubble/exmem_bubble=1 for 1 cycle; flush_cnt=1. Repeat with mem_zero=0 → no flush.
- lw in MEM, dmem_ready low 3 cycles then high → exactly 3 frozen cycles with memwb_bubble=1, then advance; stall_cnt=3; mem_err=0.
- MEM_TIMEOUT=4, dmem_ready held low → 4 frozen cycles, release on the 5th, mem_err=1 sticky, state RUN.
- Simultaneous freeze + load_use + jump → freeze outputs only; on release the jump flushes first, then the load-use stalls; counters saturate at 2^COUNT_W-1 under a long stall burst; async reset mid-freeze restores all reset values.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the 5-stage pipeline hazard controller:
//   - bit positions inside the 10-bit control word carried down the pipe
//   - next-PC source encodings driven on pc_sel
//   - state encoding of the data-memory wait FSM
package pipeline_pkg;

  // Control-word bit positions
  localparam int CTL_JUMP     = 9;
  localparam int CTL_REGDST   = 8;
  localparam int CTL_ALUSRC   = 7;
  localparam int CTL_MEMTOREG = 6;
  localparam int CTL_REGWRITE = 5;
  localparam int CTL_MEMREAD  = 4;
  localparam int CTL_MEMWRITE = 3;
  localparam int CTL_BRANCH   = 2;
  localparam int CTL_ALUOP_HI = 1;
  localparam int CTL_ALUOP_LO = 0;

  // Next-PC source select
  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;

  // Data-memory wait FSM
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, clears count
//   inc    count one event this cycle
//   count  current count (W bits)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on each event until all-ones, then hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Hazard and sequencing controller for the 5-stage pipeline. Every cycle it
// decides whether each pipeline register advances, holds or takes a bubble,
// covering data-memory wait freezes (with timeout), taken branches, jumps
// and load-use stalls.
// Ports:
//   clk, reset            clock / asynchronous active-low reset
//   id_ctrl, id_rs, id_rt control word and source registers in ID
//   ex_ctrl, ex_rt        control word and rt (load destination) in ID/EX
//   mem_ctrl, mem_zero    control word and latched zero flag in EX/MEM
//   dmem_ready            data memory finished the current access
//   pc_we .. exmem_we     pipeline register write-enables
//   pc_sel                next-PC source (seq / branch / jump)
//   ifid_flush, idex_bubble, exmem_bubble, memwb_bubble  zero-load strobes
//   mem_err               sticky memory-timeout flag
//   stall_cnt, flush_cnt  saturating performance counters
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         id_ctrl,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [9:0]         ex_ctrl,
  input  logic [4:0]         ex_rt,
  input  logic [9:0]         mem_ctrl,
  input  logic               mem_zero,
  input  logic               dmem_ready,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               idex_we,
  output logic               exmem_we,
  output logic [1:0]         pc_sel,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic               exmem_bubble,
  output logic               memwb_bubble,
  output logic               mem_err,
  output logic [COUNT_W-1:0] stall_cnt,
  output logic [COUNT_W-1:0] flush_cnt
);

  import pipeline_pkg::*;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              err_nxt;

  logic mem_access, freeze, br_taken, jump, uses_rt, load_use, at_timeout;
  logic stall_ev, flush_ev;
  logic unused_ctl;

  // Hazard event terms. Freeze drops once the wait hits the timeout so the
  // abandoned access lets the pipeline move again.
  assign at_timeout = (wait_cnt == TIMEOUT_V);
  assign mem_access = mem_ctrl[CTL_MEMREAD] | mem_ctrl[CTL_MEMWRITE];
  assign freeze     = mem_access & ~dmem_ready & ~at_timeout;
  assign br_taken   = mem_ctrl[CTL_BRANCH] & mem_zero;
  assign jump       = id_ctrl[CTL_JUMP];
  assign uses_rt    = id_ctrl[CTL_REGDST] | id_ctrl[CTL_MEMWRITE] | id_ctrl[CTL_BRANCH];
  // A jump reads no registers, so it never waits on a load
  assign load_use   = ex_ctrl[CTL_MEMREAD] & (ex_rt != 5'd0) & ~id_ctrl[CTL_JUMP] &
                      ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));

  // Control bits that steer datapath muxes but play no part in hazards
  assign unused_ctl = ^{id_ctrl[CTL_ALUSRC], id_ctrl[CTL_MEMTOREG], id_ctrl[CTL_REGWRITE],
                        id_ctrl[CTL_MEMREAD], id_ctrl[CTL_ALUOP_HI:CTL_ALUOP_LO],
                        ex_ctrl, mem_ctrl};

  // State register: FSM state, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      mem_err  <= err_nxt;
    end
  end

  // Next-state logic for the memory-wait FSM. The wait counter already
  // reads 1 in the first MEM_WAIT cycle, so a timeout of N gives N frozen
  // cycles in total.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_nxt   = mem_err;
    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (at_timeout) begin
          state_nxt = RUN;
          wait_nxt  = '0;
          err_nxt   = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // Pipeline steering, first match wins: reset, freeze, taken branch,
  // jump, load-use. A masked jump or load-use simply shows up again next
  // cycle because the instruction is still sitting in ID.
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    pc_sel       = PCSEL_SEQ;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    if (!reset) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (br_taken) begin
      pc_sel       = PCSEL_BR;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end else if (jump) begin
      pc_sel     = PCSEL_JMP;
      ifid_flush = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Performance counters; flushes only count when the pipe actually moves
  assign stall_ev = freeze | load_use;
  assign flush_ev = (br_taken | jump) & ~freeze;

  sat_counter #(.W(COUNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_ev),
    .count (stall_cnt)
  );

  sat_counter #(.W(COUNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_ev),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Scoreboard bench for pipeline_ctrl (MEM_TIMEOUT=4, COUNT_W=3). The driver
// applies one directed vector per cycle and queues the expected outputs;
// the monitor pops and compares on the falling edge.
module tb_pipeline_ctrl;

  logic       clk;
  logic       reset;
  logic [9:0] idCtrl, exCtrl, memCtrl;
  logic [4:0] idRs, idRt, exRt;
  logic       memZero, dmemReady;
  logic       pcWe, ifidWe, idexWe, exmemWe;
  logic [1:0] pcSel;
  logic       ifidFlush, idexBubble, exmemBubble, memwbBubble;
  logic       memErr;
  logic [2:0] stallCnt, flushCnt;

  // {pc_we, ifid_we, idex_we, exmem_we, pc_sel, ifid_flush, idex_bubble, exmem_bubble, memwb_bubble}
  localparam logic [9:0] NORM = 10'b1111_00_0000;
  localparam logic [9:0] RST  = 10'b0000_00_1111;
  localparam logic [9:0] FRZ  = 10'b0000_00_0001;
  localparam logic [9:0] BR   = 10'b1111_01_1110;
  localparam logic [9:0] JMP  = 10'b1111_10_1000;
  localparam logic [9:0] LU   = 10'b0011_00_0100;

  // Control words
  localparam logic [9:0] C_LW  = 10'h0F0;
  localparam logic [9:0] C_SW  = 10'h088;
  localparam logic [9:0] C_ADD = 10'h122;
  localparam logic [9:0] C_BEQ = 10'h005;
  localparam logic [9:0] C_J   = 10'h200;
  localparam logic [9:0] C_LWB = 10'h0F4;

  typedef struct {
    string      name;
    logic [9:0] ctl;
    logic       err;
    logic [2:0] stall;
    logic [2:0] flush;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [2:0] modelStall = '0;
  logic [2:0] modelFlush = '0;
  logic       modelErr   = 1'b0;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .COUNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_ctrl      (idCtrl),
    .id_rs        (idRs),
    .id_rt        (idRt),
    .ex_ctrl      (exCtrl),
    .ex_rt        (exRt),
    .mem_ctrl     (memCtrl),
    .mem_zero     (memZero),
    .dmem_ready   (dmemReady),
    .pc_we        (pcWe),
    .ifid_we      (ifidWe),
    .idex_we      (idexWe),
    .exmem_we     (exmemWe),
    .pc_sel       (pcSel),
    .ifid_flush   (ifidFlush),
    .idex_bubble  (idexBubble),
    .exmem_bubble (exmemBubble),
    .memwb_bubble (memwbBubble),
    .mem_err      (memErr),
    .stall_cnt    (stallCnt),
    .flush_cnt    (flushCnt)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one vector just after the rising edge, queue its expectation,
  // then advance the counter/error model by the events of this cycle
  task automatic applyStimulus(input string name, input logic rstN,
                               input logic [9:0] idC, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [9:0] exC, input logic [4:0] exR,
                               input logic [9:0] memC, input logic zero, input logic ready,
                               input logic [9:0] expCtl, input logic setErr);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rstN;
    idCtrl    = idC;
    idRs      = rs;
    idRt      = rt;
    exCtrl    = exC;
    exRt      = exR;
    memCtrl   = memC;
    memZero   = zero;
    dmemReady = ready;
    if (!rstN) begin
      modelStall = '0;
      modelFlush = '0;
      modelErr   = 1'b0;
    end
    e.name  = name;
    e.ctl   = expCtl;
    e.err   = modelErr;
    e.stall = modelStall;
    e.flush = modelFlush;
    q.push_back(e);
    if (rstN) begin
      if (((expCtl == FRZ) || (expCtl == LU)) && (modelStall != 3'd7)) modelStall = modelStall + 3'd1;
      if (((expCtl == BR) || (expCtl == JMP)) && (modelFlush != 3'd7)) modelFlush = modelFlush + 3'd1;
      if (setErr) modelErr = 1'b1;
    end
  endtask

  // Compare one queued expectation against the DUT outputs
  task automatic checkOutput(input exp_t e);
    logic [9:0] gotCtl;
    gotCtl = {pcWe, ifidWe, idexWe, exmemWe, pcSel, ifidFlush, idexBubble, exmemBubble, memwbBubble};
    checks++;
    if ((gotCtl !== e.ctl) || (memErr !== e.err) || (stallCnt !== e.stall) || (flushCnt !== e.flush)) begin
      errors++;
      $display("[TB] FAIL %s ctl got %b exp %b, mem_err got %b exp %b, stall got %0d exp %0d, flush got %0d exp %0d",
               e.name, gotCtl, e.ctl, memErr, e.err, stallCnt, e.stall, flushCnt, e.flush);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Directed sequence
  initial begin
    reset = 1'b0; idCtrl = '0; idRs = '0; idRt = '0; exCtrl = '0; exRt = '0;
    memCtrl = '0; memZero = 1'b0; dmemReady = 1'b1;

    applyStimulus("reset0",      0, 0, 0, 0, 0, 0, 0, 0, 1, RST, 0);
    applyStimulus("reset1",      0, 0, 0, 0, 0, 0, 0, 0, 1, RST, 0);
    applyStimulus("idle",        1, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 0);
    applyStimulus("lu_rs",       1, C_ADD, 2, 4, C_LW, 2, 0, 0, 1, LU, 0);
    applyStimulus("lu_after",    1, C_ADD, 2, 4, 0, 0, 0, 0, 1, NORM, 0);
    applyStimulus("lu_rt",       1, C_ADD, 5, 2, C_LW, 2, 0, 0, 1, LU, 0);
    applyStimulus("lu_r0",       1, C_ADD, 0, 4, C_LW, 0, 0, 0, 1, NORM, 0);
    applyStimulus("lu_sw",       1, C_SW, 7, 3, C_LW, 3, 0, 0, 1, LU, 0);
    applyStimulus("no_rt_use",   1, C_LW, 7, 3, C_LW, 3, 0, 0, 1, NORM, 0);
    applyStimulus("jmp_no_lu",   1, C_J, 2, 0, C_LW, 2, 0, 0, 1, JMP, 0);
    applyStimulus("beq_taken",   1, 0, 0, 0, 0, 0, C_BEQ, 1, 1, BR, 0);
    applyStimulus("beq_not",     1, 0, 0, 0, 0, 0, C_BEQ, 0, 1, NORM, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("frz_lat3",  1, 0, 0, 0, 0, 0, C_LW, 0, 0, FRZ, 0);
    applyStimulus("frz_done",    1, 0, 0, 0, 0, 0, C_LW, 0, 1, NORM, 0);
    applyStimulus("idle2",       1, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus("to_frz",    1, 0, 0, 0, 0, 0, C_LW, 0, 0, FRZ, 0);
    applyStimulus("to_release",  1, 0, 0, 0, 0, 0, C_LW, 0, 0, NORM, 1);
    applyStimulus("err_sticky",  1, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 0);
    applyStimulus("combo_frz",   1, C_J, 2, 0, C_LW, 2, C_LW, 0, 0, FRZ, 0);
    applyStimulus("combo_jmp",   1, C_J, 2, 0, C_LW, 2, C_LW, 0, 1, JMP, 0);
    applyStimulus("combo_lu",    1, C_ADD, 2, 4, C_LW, 2, 0, 0, 1, LU, 0);
    applyStimulus("combo_norm",  1, C_ADD, 2, 4, 0, 0, 0, 0, 1, NORM, 0);
    applyStimulus("br_frz",      1, 0, 0, 0, 0, 0, C_LWB, 1, 0, FRZ, 0);
    applyStimulus("br_frz_rel",  1, 0, 0, 0, 0, 0, C_LWB, 1, 1, BR, 0);
    applyStimulus("pre_rst_frz", 1, 0, 0, 0, 0, 0, C_LW, 0, 0, FRZ, 0);
    applyStimulus("rst_mid",     0, 0, 0, 0, 0, 0, C_LW, 0, 0, RST, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus("post_rst_frz", 1, 0, 0, 0, 0, 0, C_LW, 0, 0, FRZ, 0);
    applyStimulus("post_rst_rel", 1, 0, 0, 0, 0, 0, C_LW, 0, 0, NORM, 1);
    applyStimulus("post_err",     1, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 0);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain pending got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
